fifo_n2w: RTL and testbench
===========================

Name: fifo_n2w

Overview:
- Asymmetric FIFO: narrow write side, wide read side. This is the counterpart of the team's wide-write / narrow-read FIFO.
- Each accepted write stores one DATA_WIDTH word. Each accepted read pops two words, presented as one 2*DATA_WIDTH word.
- Used where a byte-serial producer feeds a word-parallel consumer.
- Contains the storage plus a pointer/status controller.

Parameters:
- DATA_WIDTH, 8, width of one write word; read word is 2*DATA_WIDTH.
- ADDR_WIDTH, 3, storage depth DEPTH = 2**ADDR_WIDTH narrow words; must be >= 1.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-high reset.
- wr  in  1  write request.
- w_data  in  DATA_WIDTH  write data.
- rd  in  1  read (pop) request.
- r_data  out  2*DATA_WIDTH  wide read data, valid while ~empty.
- full  out  1  no room for one narrow word.
- empty  out  1  fewer than two narrow words stored (no complete wide word).
- word_cnt  out  ADDR_WIDTH+1  narrow words stored, 0..DEPTH.
- ovf  out  1  one-cycle pulse: a write was rejected the previous cycle.
- udf  out  1  one-cycle pulse: a read was rejected the previous cycle.

Behaviour:
- Clocking and reset: one clock domain. Reset is asynchronous and active-high. Port names are clk and reset.
- Registers:
  - wr_ptr: ADDR_WIDTH bits.
  - rd_ptr: ADDR_WIDTH bits, always even.
  - cnt: ADDR_WIDTH+1 bits.
  - ovf, udf flags.
  - Storage array of DEPTH x DATA_WIDTH; the array is not reset.
- Reset values: wr_ptr=0, rd_ptr=0, cnt=0, so full=0, empty=1, word_cnt=0. ovf=0, udf=0. r_data is don't-care while empty.
- Status decode, combinational from cnt: full = (cnt == DEPTH); empty = (cnt < 2); word_cnt = cnt.
- Write acceptance: wr_acc = wr & ~full, using the current-cycle full.
  - On the edge, mem[wr_ptr] <= w_data.
  - wr_ptr <= wr_ptr + 1, wrapping modulo DEPTH.
- Read acceptance: rd_acc = rd & ~empty.
  - On the edge, rd_ptr <= rd_ptr + 2, wrapping modulo DEPTH.
- Counter update: cnt <= cnt + wr_acc - 2*rd_acc, in ADDR_WIDTH+1-bit arithmetic; it never leaves 0..DEPTH.
- Read data: r_data = {mem[rd_ptr+1], mem[rd_ptr]}, combinational with zero latency.
  - The low half is the older (first-written) word.
  - rd_ptr+1 never wraps, because rd_ptr is even and DEPTH is even.
- Simultaneous wr and rd: each is judged independently against the current flags; there is no bypass.
  - At cnt=1, the read is rejected and the write is accepted.
  - At cnt=DEPTH, the write is rejected and the read is accepted.
- Rejected requests leave the pointers, cnt and storage unchanged.
  - ovf <= wr & full; udf <= rd & empty. Each is registered and clears the next cycle unless repeated.
- Wrap-around is pure modulo-DEPTH pointer arithmetic. Ordering is preserved across the 7->0 boundary at DEPTH=8.
- Reset mid-operation: on assertion between edges, outputs go to reset values immediately. Stored contents are retained but unreachable. After deassertion the FIFO behaves as empty.
- No X on status outputs at any time after reset.

Decomposition:
- Package fifo_n2w_pkg holds:
  - function depth_of(ADDR_WIDTH);
  - localparam-style constants for read-step = 2 and write-step = 1.
- Sub-module fifo_n2w_ctrl: pointers, cnt, full/empty/word_cnt decode, ovf/udf.
  - Outputs w_addr and r_addr, both ADDR_WIDTH wide, plus wr_en.
- Top level fifo_n2w: storage array, r_data concatenation, and one instance of fifo_n2w_ctrl.

Test Plan (DATA_WIDTH=8, ADDR_WIDTH=3):
1. Basic write/read.
   - After reset: empty=1, full=0, word_cnt=0.
   - Write 0x11 -> word_cnt=1, empty=1.
   - Write 0x22 -> empty=0, r_data=0x2211.
   - rd -> word_cnt=0, empty=1.
2. Fill and overflow.
   - Write 0x01..0x08 -> full=1, word_cnt=8.
   - 9th write 0xFF -> ovf=1 for one cycle; word_cnt stays 8.
   - Four reads return 0x0201, 0x0403, 0x0605, 0x0807, then empty=1.
3. Wrap-around.
   - Write 0xA0..0xA5, read once (0xA1A0), read once (0xA3A2).
   - Write 0xA6..0xA9, crossing index 7->0.
   - Reads return 0xA5A4, 0xA7A6, 0xA9A8, then empty=1, word_cnt=0.
4. Simultaneous wr and rd.
   - At cnt=3 -> cnt=2, data order intact.
   - At cnt=1 -> udf=1, cnt=2.
   - At cnt=8 -> ovf=1, cnt=6.
   - rd on empty with wr=0 -> udf=1, state unchanged.
5. Reset mid-operation.
   - With cnt=5, assert reset mid-cycle -> full=0, empty=1, word_cnt=0 before the next edge.
   - Release, write 0xAA then 0xBB -> r_data=0xBBAA.

Source files
------------

// File: rtl/fifo_n2w_pkg.sv
// rtl/fifo_n2w_pkg.sv - shared constants and helpers for the narrow-write / wide-read FIFO
package fifo_n2w_pkg;

  localparam int WR_STEP = 1;
  localparam int RD_STEP = 2;

  function automatic int depth_of(input int addr_width);
    return 1 << addr_width;
  endfunction

endpackage

// File: rtl/fifo_n2w_ctrl.sv
// rtl/fifo_n2w_ctrl.sv - pointer, occupancy and status controller for fifo_n2w
module fifo_n2w_ctrl
  import fifo_n2w_pkg::*;
#(
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr,
  input  logic                  rd,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [ADDR_WIDTH-1:0] r_addr,
  output logic                  wr_en,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   word_cnt,
  output logic                  ovf,
  output logic                  udf
);

  localparam int DEPTH = depth_of(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0]   DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   CNT_W   = (ADDR_WIDTH+1)'(WR_STEP);
  localparam logic [ADDR_WIDTH:0]   CNT_R   = (ADDR_WIDTH+1)'(RD_STEP);
  localparam logic [ADDR_WIDTH-1:0] PTR_W   = ADDR_WIDTH'(WR_STEP);
  localparam logic [ADDR_WIDTH-1:0] PTR_R   = ADDR_WIDTH'(RD_STEP);

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   cnt;
  logic                  wr_acc;
  logic                  rd_acc;

  assign full     = (cnt == DEPTH_C);
  // A wide word needs two narrow entries, so one leftover byte still reads as empty.
  assign empty    = (cnt < CNT_R);
  assign word_cnt = cnt;
  assign wr_acc   = wr & ~full;
  assign rd_acc   = rd & ~empty;
  assign wr_en    = wr_acc;
  assign w_addr   = wr_ptr;
  assign r_addr   = rd_ptr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
      udf    <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_W;
      if (rd_acc) rd_ptr <= rd_ptr + PTR_R;
      cnt <= cnt + (wr_acc ? CNT_W : '0) - (rd_acc ? CNT_R : '0);
      ovf <= wr & full;
      udf <= rd & empty;
    end
  end

endmodule

// File: rtl/fifo_n2w.sv
// rtl/fifo_n2w.sv - asymmetric FIFO: one narrow word in per write, two narrow words out per read
module fifo_n2w
  import fifo_n2w_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr,
  input  logic [DATA_WIDTH-1:0]   w_data,
  input  logic                    rd,
  output logic [2*DATA_WIDTH-1:0] r_data,
  output logic                    full,
  output logic                    empty,
  output logic [ADDR_WIDTH:0]     word_cnt,
  output logic                    ovf,
  output logic                    udf
);

  localparam int DEPTH = depth_of(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] r_addr_hi;
  logic                  wr_en;

  fifo_n2w_ctrl #(.ADDR_WIDTH(ADDR_WIDTH)) u_ctrl (
    .clk      (clk),
    .reset    (reset),
    .wr       (wr),
    .rd       (rd),
    .w_addr   (w_addr),
    .r_addr   (r_addr),
    .wr_en    (wr_en),
    .full     (full),
    .empty    (empty),
    .word_cnt (word_cnt),
    .ovf      (ovf),
    .udf      (udf)
  );

  always_ff @(posedge clk) begin
    if (wr_en) mem[w_addr] <= w_data;
  end

  // r_addr is always even, so the upper half never wraps past the array end.
  assign r_addr_hi = r_addr + ADDR_WIDTH'(1);
  assign r_data    = {mem[r_addr_hi], mem[r_addr]};

endmodule

// File: tb/tb_fifo_n2w.sv
// tb/tb_fifo_n2w.sv - self-checking bench for fifo_n2w: vector table, corner sequences, random vs queue model
module tb_fifo_n2w;

  localparam int DW    = 8;
  localparam int AW    = 3;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr;
  logic          rd;
  logic [DW-1:0] w_data;
  logic [2*DW-1:0] r_data;
  logic          full;
  logic          empty;
  logic [AW:0]   word_cnt;
  logic          ovf;
  logic          udf;

  always #5 clk = ~clk;

  fifo_n2w #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk      (clk),
    .reset    (reset),
    .wr       (wr),
    .w_data   (w_data),
    .rd       (rd),
    .r_data   (r_data),
    .full     (full),
    .empty    (empty),
    .word_cnt (word_cnt),
    .ovf      (ovf),
    .udf      (udf)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: a queue of stored bytes, oldest first.
  logic [7:0] q[$];
  logic       m_ovf = 1'b0;
  logic       m_udf = 1'b0;

  typedef struct {
    logic        w;
    logic        r;
    logic [7:0]  d;
    int          cnt;
    logic        o;
    logic        u;
    logic        cr;
    logic [15:0] rdat;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic w, input logic r, input logic [7:0] d, input int cnt,
                              input logic o, input logic u, input logic cr, input logic [15:0] rdat);
    vec_t v;
    v.w = w; v.r = r; v.d = d; v.cnt = cnt; v.o = o; v.u = u; v.cr = cr; v.rdat = rdat;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cycle(input logic w, input logic r, input logic [7:0] d);
    logic mfull;
    logic mempty;
    mfull  = (q.size() == DEPTH);
    mempty = (q.size() < 2);
    wr = w; rd = r; w_data = d;
    @(posedge clk);
    #1;
    m_ovf = w && mfull;
    m_udf = r && mempty;
    if (r && !mempty) begin
      void'(q.pop_front());
      void'(q.pop_front());
    end
    if (w && !mfull) q.push_back(d);
    wr = 1'b0; rd = 1'b0;
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_cnt"},   32'(word_cnt), 32'(q.size()));
    chk({tag, "_empty"}, 32'(empty),    32'(q.size() < 2));
    chk({tag, "_full"},  32'(full),     32'(q.size() == DEPTH));
    chk({tag, "_ovf"},   32'(ovf),      32'(m_ovf));
    chk({tag, "_udf"},   32'(udf),      32'(m_udf));
    if (q.size() >= 2) chk({tag, "_rdata"}, 32'(r_data), {16'h0, q[1], q[0]});
  endtask

  initial begin
    reset = 1'b1; wr = 1'b0; rd = 1'b0; w_data = '0;

    // 1: basic
    add(1, 0, 8'h11, 1, 0, 0, 0, 16'h0);
    add(1, 0, 8'h22, 2, 0, 0, 1, 16'h2211);
    add(0, 1, 8'h00, 0, 0, 0, 0, 16'h0);
    // 2: fill, overflow, drain
    for (int i = 1; i <= 8; i++) add(1, 0, 8'(i), i, 0, 0, (i >= 2), 16'h0201);
    add(1, 0, 8'hFF, 8, 1, 0, 1, 16'h0201);
    add(0, 1, 8'h00, 6, 0, 0, 1, 16'h0403);
    add(0, 1, 8'h00, 4, 0, 0, 1, 16'h0605);
    add(0, 1, 8'h00, 2, 0, 0, 1, 16'h0807);
    add(0, 1, 8'h00, 0, 0, 0, 0, 16'h0);
    // 3: wrap-around across index 7->0
    for (int i = 0; i < 6; i++) add(1, 0, 8'(8'hA0 + i), i + 1, 0, 0, (i >= 1), 16'hA1A0);
    add(0, 1, 8'h00, 4, 0, 0, 1, 16'hA3A2);
    add(0, 1, 8'h00, 2, 0, 0, 1, 16'hA5A4);
    for (int i = 6; i < 10; i++) add(1, 0, 8'(8'hA0 + i), i - 3, 0, 0, 1, 16'hA5A4);
    add(0, 1, 8'h00, 4, 0, 0, 1, 16'hA7A6);
    add(0, 1, 8'h00, 2, 0, 0, 1, 16'hA9A8);
    add(0, 1, 8'h00, 0, 0, 0, 0, 16'h0);
    // 4: simultaneous wr+rd
    add(1, 0, 8'hB0, 1, 0, 0, 0, 16'h0);
    add(1, 0, 8'hB1, 2, 0, 0, 1, 16'hB1B0);
    add(1, 0, 8'hB2, 3, 0, 0, 1, 16'hB1B0);
    add(1, 1, 8'hB3, 2, 0, 0, 1, 16'hB3B2);
    add(0, 1, 8'h00, 0, 0, 0, 0, 16'h0);
    add(1, 0, 8'hC0, 1, 0, 0, 0, 16'h0);
    add(1, 1, 8'hC1, 2, 0, 1, 1, 16'hC1C0);
    for (int i = 2; i < 8; i++) add(1, 0, 8'(8'hC0 + i), i + 1, 0, 0, 1, 16'hC1C0);
    add(1, 1, 8'hFF, 6, 1, 0, 1, 16'hC3C2);
    add(0, 1, 8'h00, 4, 0, 0, 1, 16'hC5C4);
    add(0, 1, 8'h00, 2, 0, 0, 1, 16'hC7C6);
    add(0, 1, 8'h00, 0, 0, 0, 0, 16'h0);
    add(0, 1, 8'h00, 0, 0, 1, 0, 16'h0);
    add(0, 0, 8'h00, 0, 0, 0, 0, 16'h0);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full",  32'(full),  32'd0);
    chk("rst_cnt",   32'(word_cnt), 32'd0);
    chk("rst_ovf",   32'(ovf), 32'd0);
    chk("rst_udf",   32'(udf), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      cycle(tbl[i].w, tbl[i].r, tbl[i].d);
      chk($sformatf("v%0d_cnt", i),   32'(word_cnt), 32'(tbl[i].cnt));
      chk($sformatf("v%0d_empty", i), 32'(empty),    32'(tbl[i].cnt < 2));
      chk($sformatf("v%0d_full", i),  32'(full),     32'(tbl[i].cnt == DEPTH));
      chk($sformatf("v%0d_ovf", i),   32'(ovf),      32'(tbl[i].o));
      chk($sformatf("v%0d_udf", i),   32'(udf),      32'(tbl[i].u));
      if (tbl[i].cr) chk($sformatf("v%0d_rdata", i), 32'(r_data), 32'(tbl[i].rdat));
    end

    // 5: reset asserted between edges with five bytes stored
    for (int i = 0; i < 5; i++) cycle(1, 0, 8'(8'h50 + i));
    check_model("pre_rst");
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_full",  32'(full),     32'd0);
    chk("mid_rst_empty", 32'(empty),    32'd1);
    chk("mid_rst_cnt",   32'(word_cnt), 32'd0);
    q.delete(); m_ovf = 1'b0; m_udf = 1'b0;
    #2 reset = 1'b0;
    cycle(1, 0, 8'hAA);
    cycle(1, 0, 8'hBB);
    chk("post_rst_rdata", 32'(r_data),   32'h0000BBAA);
    chk("post_rst_cnt",   32'(word_cnt), 32'd2);

    // Random traffic in phases biased toward filling, draining, and balanced.
    for (int i = 0; i < 3000; i++) begin
      int wp;
      int rp;
      logic w;
      logic r;
      case ((i / 250) % 3)
        0:       begin wp = 80; rp = 25; end
        1:       begin wp = 25; rp = 80; end
        default: begin wp = 55; rp = 50; end
      endcase
      w = ($urandom_range(0, 99) < wp);
      r = ($urandom_range(0, 99) < rp);
      cycle(w, r, 8'($urandom));
      check_model($sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
